// File: rtl/uart_rx_checker.sv
// Single-channel 8N1 UART receiver with a byte checker for looped-back link tests.
// Each received byte is compared with EXPECTED, and saturating good/bad tallies are kept.
module uart_rx_checker #(
  parameter int          CLKS_PER_BIT = 250,
  parameter logic [7:0]  EXPECTED     = 8'h00,
  parameter int          COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [7:0]         data_out,
  output logic               data_valid,
  output logic               frame_err,
  output logic               match,
  output logic [COUNT_W-1:0] ok_count,
  output logic [COUNT_W-1:0] err_count
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_sync1;
  logic               r_sync2;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_ferr;
  logic               r_match;
  logic [COUNT_W-1:0] r_ok;
  logic [COUNT_W-1:0] r_err;

  logic               w_rx_s;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_take_bit;
  logic               w_good;
  logic               w_bad;
  logic               w_is_expected;

  assign w_rx_s        = r_sync2;
  assign w_is_expected = (r_shift == EXPECTED);

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_take_bit   = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = S_START;
          w_cnt_clr    = 1'b1;
        end
      end
      S_START: begin
        // A start bit that is gone by mid-bit is treated as line noise.
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr    = 1'b1;
          w_state_next = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_clr  = 1'b1;
          w_take_bit = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_good       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_bad        = 1'b1;
            w_state_next = S_BREAK;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_BREAK: begin
        if (w_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_match   <= 1'b0;
      r_ok      <= '0;
      r_err     <= '0;
    end else begin
      r_state <= w_state_next;
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if (w_take_bit) begin
        r_bit_idx <= r_bit_idx + 1'b1;
        r_shift   <= {w_rx_s, r_shift[7:1]};
      end

      if (w_good) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_match <= w_is_expected;
        if (w_is_expected) begin
          if (r_ok != '1) r_ok <= r_ok + 1'b1;
        end else begin
          if (r_err != '1) r_err <= r_err + 1'b1;
        end
      end

      if (w_bad) begin
        r_ferr <= 1'b1;
        if (r_err != '1) r_err <= r_err + 1'b1;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign match      = r_match;
  assign ok_count   = r_ok;
  assign err_count  = r_err;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Directed bench for uart_rx_checker: good, bad, glitch, break, saturation and mid-frame reset.
module tb_uart_rx_checker;

  localparam int         CPB   = 8;
  localparam int         CW    = 4;
  localparam logic [7:0] EXPV  = 8'h5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [7:0]    data_out;
  logic          data_valid;
  logic          frame_err;
  logic          match;
  logic [CW-1:0] ok_count;
  logic [CW-1:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int dv_mark;
  int fe_mark;

  uart_rx_checker #(
    .CLKS_PER_BIT(CPB),
    .EXPECTED    (EXPV),
    .COUNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .match     (match),
    .ok_count  (ok_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse widths are counted in cycles so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (frame_err)  fe_cnt++;
    if (data_valid && frame_err) check("dv_fe_exclusive", 32'd1, 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    dv_mark = dv_cnt;
    fe_mark = fe_cnt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    $display("frame %02h stop=%0b -> data_out=%02h match=%0b ok=%0d err=%0d",
             b, stop, data_out, match, ok_count, err_count);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(4);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_ok", ok_count, 4'h0);
    check("rst_err", err_count, 4'h0);
    rst = 1'b0;
    tick(2);

    // Single good frame
    mark();
    send_frame(8'h5A, 1'b1);
    check("t1_dv_pulses", dv_cnt - dv_mark, 1);
    check("t1_data", data_out, 8'h5A);
    check("t1_match", match, 1'b1);
    check("t1_ok", ok_count, 4'h1);
    check("t1_err", err_count, 4'h0);

    // Back-to-back mismatch then match
    do_reset();
    mark();
    send_frame(8'hA5, 1'b1);
    check("t2a_dv_pulses", dv_cnt - dv_mark, 1);
    check("t2a_data", data_out, 8'hA5);
    check("t2a_match", match, 1'b0);
    check("t2a_err", err_count, 4'h1);
    check("t2a_ok", ok_count, 4'h0);
    mark();
    send_frame(8'h5A, 1'b1);
    check("t2b_dv_pulses", dv_cnt - dv_mark, 1);
    check("t2b_data", data_out, 8'h5A);
    check("t2b_match", match, 1'b1);
    check("t2b_ok", ok_count, 4'h1);
    check("t2b_err", err_count, 4'h1);

    // Short low glitch is ignored and the receiver stays usable
    do_reset();
    mark();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    $display("glitch 3 clocks -> ok=%0d err=%0d", ok_count, err_count);
    check("t3_dv_pulses", dv_cnt - dv_mark, 0);
    check("t3_fe_pulses", fe_cnt - fe_mark, 0);
    check("t3_ok", ok_count, 4'h0);
    check("t3_err", err_count, 4'h0);
    send_frame(8'h5A, 1'b1);
    check("t3_after_data", data_out, 8'h5A);
    check("t3_after_ok", ok_count, 4'h1);

    // Bad stop bit followed by a held-low line, then a good frame
    do_reset();
    mark();
    send_frame(8'h3C, 1'b0);
    tick(40 - CPB);
    rx = 1'b1;
    tick(16);
    check("t4_fe_pulses", fe_cnt - fe_mark, 1);
    check("t4_dv_pulses", dv_cnt - dv_mark, 0);
    check("t4_err", err_count, 4'h1);
    check("t4_data_held", data_out, 8'h00);
    check("t4_match_held", match, 1'b0);
    mark();
    send_frame(8'h5A, 1'b1);
    check("t4b_dv_pulses", dv_cnt - dv_mark, 1);
    check("t4b_fe_pulses", fe_cnt - fe_mark, 0);
    check("t4b_data", data_out, 8'h5A);
    check("t4b_ok", ok_count, 4'h1);
    check("t4b_err", err_count, 4'h1);

    // Saturation of ok_count
    do_reset();
    for (int f = 1; f <= 17; f++) begin
      send_frame(8'h5A, 1'b1);
      if (f >= 14) check($sformatf("t5_ok_f%0d", f), ok_count, (f > 15) ? 4'hF : f[3:0]);
    end
    check("t5_err", err_count, 4'h0);

    // Reset during data bit 4 discards the partial frame
    mark();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = EXPV[i];
      tick(CPB);
    end
    rx = EXPV[4];
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    check("t6_rst_data", data_out, 8'h00);
    check("t6_rst_match", match, 1'b0);
    check("t6_rst_ok", ok_count, 4'h0);
    check("t6_rst_valid", data_valid, 1'b0);
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(16);
    $display("reset mid-frame -> ok=%0d err=%0d", ok_count, err_count);
    check("t6_no_dv", dv_cnt - dv_mark, 0);
    check("t6_no_fe", fe_cnt - fe_mark, 0);
    mark();
    send_frame(8'h5A, 1'b1);
    check("t6_dv_pulses", dv_cnt - dv_mark, 1);
    check("t6_data", data_out, 8'h5A);
    check("t6_ok", ok_count, 4'h1);
    check("t6_err", err_count, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_checker.md
Name: uart_rx_checker

Overview:
- Receive-side counterpart of the cycled UART transmitter bank: a single-channel 8N1 UART receiver that oversamples one serial line on the fast system clock.
- Recovers each byte and compares it against the constant the matching transmitter channel sends; keeps saturating good/bad frame tallies.
- One instance is placed per looped-back channel, for board-level link checking of the many-UART output bus.

Parameters:
- CLKS_PER_BIT, 250, system clocks per UART bit (25 MHz clk / 100 kbaud); must be >= 4.
- EXPECTED, 0, byte value (0..255) the channel is expected to carry.
- COUNT_W, 16, width of the good/bad tally counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  8  last correctly framed byte; reset 8'h00.
- data_valid  out  1  one-clock pulse when data_out is updated; reset 0.
- frame_err  out  1  one-clock pulse on a bad stop bit; reset 0.
- match  out  1  1 when the last good frame equalled EXPECTED; reset 0.
- ok_count  out  COUNT_W  saturating count of good frames equal to EXPECTED; reset 0.
- err_count  out  COUNT_W  saturating count of mismatches plus framing errors; reset 0.

Behaviour:
- Input sync: rx passes through a 2-FF synchronizer (both stages reset to 1); rx_s is the second stage. All decisions use rx_s only.
- Timing: a baud counter runs 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 (integer division).
- IDLE: when rx_s = 0, clear the counter and go to START.
- START: count HALF cycles, then sample rx_s.
  - rx_s = 0: valid start bit; go to DATA with bit index 0 and counter cleared.
  - rx_s = 1: glitch; return to IDLE with no outputs or counts changed.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s = 1: on the next clock, data_out <= byte and data_valid = 1 for exactly one cycle; match <= (byte == EXPECTED); increment ok_count if equal, otherwise err_count. Then go to IDLE.
  - rx_s = 0: frame_err = 1 for one cycle; err_count increments; data_out and match are held. Go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. This prevents false restarts inside a held-low line.
- Latency: data_valid rises 1 clock after the mid-stop-bit sample, which is about 2 sync clocks + 9.5 bit times after the falling start edge.
- Back-to-back frames: a start bit arriving immediately after the stop-bit sample is detected; IDLE is re-entered within half a bit time.
- Saturation: counters stick at all-ones and never wrap.
- Simultaneous events: only one of data_valid or frame_err can pulse per frame.
- Reset mid-frame: rst at any state forces IDLE, clears the shift register, bit index, counters and all outputs, and sets the synchronizer to 1. The partial frame is discarded and produces no pulse.

Test Plan (CLKS_PER_BIT=8, COUNT_W=4 unless stated):
- EXPECTED=8'h5A; drive one 8N1 frame 0x5A -> single data_valid pulse, data_out=8'h5A, match=1, ok_count=1, err_count=0.
- EXPECTED=8'h5A; frame 0xA5 then frame 0x5A back-to-back -> two data_valid pulses; after the first, match=0 and err_count=1; after the second, match=1 and ok_count=1.
- rx low for 3 clocks then high -> no data_valid, no frame_err, all counts 0, FSM back in IDLE.
- Frame 0x3C with stop bit 0, line held low 40 clocks, then high, then frame 0x5A -> one frame_err pulse, err_count=1, data_out unchanged; then data_valid with 0x5A and ok_count=1.
- 17 frames of 0x5A -> ok_count saturates at 4'hF and stays there after the 16th and 17th frames.
- Assert rst during DATA bit 4 of a frame, release, then send 0x5A -> no pulse from the aborted frame, outputs 0 during reset, then a clean receive with ok_count=1.
